// File: rtl/uart_chk_pkg.sv
// Shared definitions for the UART sequence checker: FSM states and timeout sizing.
package uart_chk_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_t;

  // Idle cycles before an established sync/lock is abandoned.
  function automatic int unsigned timeout_cycles(input int unsigned clockfrq,
                                                 input int unsigned timeoutus);
    return (clockfrq / 1000000) * timeoutus;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/uart_chk.sv
// Checks that a UART byte stream follows an incrementing mod-256 pattern and
// reports lock, per-byte mismatches, idle timeouts and error statistics.
module uart_chk
  import uart_chk_pkg::*;
#(
  parameter int unsigned CLOCKFRQ  = 240000000,
  parameter int unsigned LOCKCOUNT = 4,
  parameter int unsigned LOSSCOUNT = 8,
  parameter int unsigned TIMEOUTUS = 1000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  input  logic        clear,
  output logic        locked,
  output logic        mismatch,
  output logic        timeout,
  output logic [7:0]  expByte,
  output logic [31:0] byteCount,
  output logic [15:0] errCount,
  output logic [15:0] rxErrCount,
  output logic [1:0]  dbg_state
);

  localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLOCKFRQ, TIMEOUTUS);

  // received is a one-cycle strobe with no backpressure: each cycle it is high
  // is one byte, and clear in the same cycle discards that byte.
  chk_state_t  r_state, w_state_nx;
  logic [7:0]  r_exp, w_exp_nx;
  logic [7:0]  r_run, w_run_nx;
  logic [7:0]  r_miss, w_miss_nx;
  logic [31:0] r_idle, w_idle_nx;
  logic [31:0] r_bcnt, w_bcnt_nx;
  logic        r_mis, w_mis_nx;
  logic        r_to, w_to_nx;
  logic        w_err_inc, w_rxerr_inc;
  logic        w_good;

  assign w_good = received & ~recv_error;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_HUNT;
      r_exp   <= 8'd0;
      r_run   <= 8'd0;
      r_miss  <= 8'd0;
      r_idle  <= 32'd0;
      r_bcnt  <= 32'd0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_exp   <= w_exp_nx;
      r_run   <= w_run_nx;
      r_miss  <= w_miss_nx;
      r_idle  <= w_idle_nx;
      r_bcnt  <= w_bcnt_nx;
      r_mis   <= w_mis_nx;
      r_to    <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_exp_nx    = r_exp;
    w_run_nx    = r_run;
    w_miss_nx   = r_miss;
    w_idle_nx   = r_idle;
    w_bcnt_nx   = r_bcnt;
    w_mis_nx    = 1'b0;
    w_to_nx     = 1'b0;
    w_err_inc   = 1'b0;
    w_rxerr_inc = 1'b0;
    if (clear) begin
      w_state_nx = ST_HUNT;
      w_exp_nx   = 8'd0;
      w_run_nx   = 8'd0;
      w_miss_nx  = 8'd0;
      w_idle_nx  = 32'd0;
      w_bcnt_nx  = 32'd0;
    end else if (received) begin
      w_idle_nx   = 32'd0;
      w_rxerr_inc = recv_error;
      case (r_state)
        ST_HUNT: begin
          if (w_good) begin
            w_exp_nx  = rx_byte + 8'd1;
            w_run_nx  = 8'd1;
            w_miss_nx = 8'd0;
            w_state_nx = (LOCKCOUNT == 1) ? ST_LOCKED : ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (!w_good) begin
            w_state_nx = ST_HUNT;
          end else if (rx_byte == r_exp) begin
            w_exp_nx = r_exp + 8'd1;
            w_run_nx = r_run + 8'd1;
            if ((r_run + 8'd1) == 8'(LOCKCOUNT)) begin
              w_state_nx = ST_LOCKED;
              w_miss_nx  = 8'd0;
            end
          end else begin
            w_exp_nx = rx_byte + 8'd1;
            w_run_nx = 8'd1;
          end
        end
        ST_LOCKED: begin
          w_bcnt_nx = r_bcnt + 32'd1;
          if (!w_good) begin
            // Errored byte still occupies a sequence slot.
            w_exp_nx = r_exp + 8'd1;
          end else if (rx_byte == r_exp) begin
            w_exp_nx  = r_exp + 8'd1;
            w_miss_nx = 8'd0;
          end else begin
            w_mis_nx  = 1'b1;
            w_err_inc = 1'b1;
            w_exp_nx  = rx_byte + 8'd1;
            w_miss_nx = r_miss + 8'd1;
            if ((r_miss + 8'd1) == 8'(LOSSCOUNT)) begin
              w_state_nx = ST_HUNT;
            end
          end
        end
        default: w_state_nx = ST_HUNT;
      endcase
    end else if (r_state != ST_HUNT) begin
      w_idle_nx = r_idle + 32'd1;
      if ((r_idle + 32'd1) == 32'(TIMEOUT_CYC)) begin
        w_state_nx = ST_HUNT;
        w_to_nx    = 1'b1;
      end
    end
  end

  sat_cnt #(.WIDTH(16)) u_err_cnt (
    .clk   (clk),
    .nRst  (nRst),
    .i_clr (clear),
    .i_inc (w_err_inc),
    .o_cnt (errCount)
  );

  sat_cnt #(.WIDTH(16)) u_rxerr_cnt (
    .clk   (clk),
    .nRst  (nRst),
    .i_clr (clear),
    .i_inc (w_rxerr_inc),
    .o_cnt (rxErrCount)
  );

  assign locked    = (r_state == ST_LOCKED);
  assign mismatch  = r_mis;
  assign timeout   = r_to;
  assign expByte   = r_exp;
  assign byteCount = r_bcnt;
  assign dbg_state = r_state;

endmodule
